rf_write_arbiter: RTL and testbench

Arbitrates the single register-file write port between the pipeline writeback stage and the long-latency unit (mult/div, multi-cycle loads). Tracks outstanding long-latency destinations in a 32-bit pending scoreboard that the issue stage uses for RAW/WAW stalls. Sits between WriteBack/long-latency unit and the register file. Drives a registered write port.

---
 rtl/rf_write_arbiter_pkg.sv | 31 +++
 rtl/rf_write_arbiter_if.sv | 31 +++
 rtl/rf_write_arbiter_skid_fifo.sv | 52 +++++
 rtl/rf_write_arbiter.sv | 108 ++++++++++
 tb/tb_rf_write_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// mips_wb_pkg: shared definitions for the register-file write arbiter.
//   - writeback opcode classes and the set of classes that write a register
//   - long-latency result buffer entry type
//   - default result buffer depth
package mips_wb_pkg;

  localparam int FIFO_DEPTH_DEF = 2;

  localparam logic [5:0] OPT_ALU_R = 6'h00;
  localparam logic [5:0] OPT_ALU_I = 6'h01;
  localparam logic [5:0] OPT_LOAD  = 6'h02;
  localparam logic [5:0] OPT_STORE = 6'h03;
  localparam logic [5:0] OPT_SHIFT = 6'h04;
  localparam logic [5:0] OPT_LUI   = 6'h05;
  localparam logic [5:0] OPT_LINK  = 6'h06;
  localparam logic [5:0] OPT_MOVE  = 6'h13;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic wb_optype_we(input logic [5:0] optype);
    case (optype)
      OPT_ALU_R, OPT_ALU_I, OPT_LOAD, OPT_SHIFT,
      OPT_LUI, OPT_LINK, OPT_MOVE: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: request-side bus of the register-file write arbiter.
//   wb_*    : writeback stage result (valid, opcode class, destination, data)
//   lu_*    : long-latency result valid/ready handshake with destination/data
//   issue_* : destination of an instruction issued to the long-latency unit
// master = pipeline/long-latency side, slave = arbiter.
interface rf_write_arbiter_if;
  logic        wb_valid;
  logic [5:0]  wb_optype;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;

  modport master (
    output wb_valid, wb_optype, wb_addr, wb_data,
    output lu_valid, lu_addr, lu_data,
    output issue_valid, issue_addr,
    input  lu_ready
  );

  modport slave (
    input  wb_valid, wb_optype, wb_addr, wb_data,
    input  lu_valid, lu_addr, lu_data,
    input  issue_valid, issue_addr,
    output lu_ready
  );
endinterface

// File: rtl/rf_write_arbiter_skid_fifo.sv
// wb_skid_fifo: synchronous FIFO buffering long-latency results until the
// register-file write port is free.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push, din    : enqueue (ignored when full)
//   pop, dout    : dequeue (ignored when empty); dout shows the head entry
//   full, empty  : status
//   count        : number of stored entries
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module wb_skid_fifo
  import mips_wb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              din,
  input  logic                   pop,
  output wb_entry_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port between the
// writeback stage and the long-latency unit, and keeps the pending-destination
// scoreboard used by issue for RAW/WAW stalls.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : rf_write_arbiter_if.slave (wb_*, lu_* handshake, issue_*)
//   pend      : pending-destination bitmap
//   stall_req : registered; WB must send a bubble while high
//   rf_we/rf_addr/rf_data : registered register-file write port
//   err_waw   : sticky, WB wrote a register still pending from the LU
// Optional build macro WB_FWD_EN adds fwd_valid/fwd_addr/fwd_data, the
// unregistered write selected this cycle, for decode-stage bypass.
module rf_write_arbiter
  import mips_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  rf_write_arbiter_if.slave         bus,
  output logic [31:0]               pend,
  output logic                      stall_req,
  output logic                      rf_we,
  output logic [4:0]                rf_addr,
  output logic [31:0]               rf_data,
  output logic                      err_waw
`ifdef WB_FWD_EN
  ,
  output logic                      fwd_valid,
  output logic [4:0]                fwd_addr,
  output logic [31:0]               fwd_data
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] STALL_LVL = CW'(FIFO_DEPTH - 1);

  logic          wb_req, lu_xfer, push, pop;
  logic          full, empty;
  logic [CW-1:0] count, count_nxt;
  wb_entry_t     head, lu_entry;
  logic          sel_we;
  logic [4:0]    sel_addr;
  logic [31:0]   sel_data;
  logic [31:0]   pend_nxt;

  assign wb_req = bus.wb_valid && wb_optype_we(bus.wb_optype) && (bus.wb_addr != 5'd0);

  assign bus.lu_ready = !rst && !full;
  assign lu_xfer      = bus.lu_valid && bus.lu_ready;
  // Results for r0 complete the handshake but are never stored.
  assign push         = lu_xfer && (bus.lu_addr != 5'd0);
  // WB owns the port whenever it requests; the buffer drains only in gaps.
  assign pop          = !wb_req && !empty;

  assign lu_entry.addr = bus.lu_addr;
  assign lu_entry.data = bus.lu_data;

  wb_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (lu_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign count_nxt = count + CW'(push) - CW'(pop);

  assign sel_we   = wb_req || pop;
  assign sel_addr = wb_req ? bus.wb_addr : head.addr;
  assign sel_data = wb_req ? bus.wb_data : head.data;

  // Clear on commit first, then set on issue, so a same-cycle reissue wins.
  always_comb begin
    pend_nxt = pend;
    if (pop) pend_nxt[head.addr] = 1'b0;
    if (bus.issue_valid && (bus.issue_addr != 5'd0)) pend_nxt[bus.issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we     <= 1'b0;
      rf_addr   <= '0;
      rf_data   <= '0;
      pend      <= '0;
      stall_req <= 1'b0;
      err_waw   <= 1'b0;
    end else begin
      rf_we <= sel_we;
      if (sel_we) begin
        rf_addr <= sel_addr;
        rf_data <= sel_data;
      end
      pend      <= pend_nxt;
      // Raised one entry early so a drain slot exists before the buffer fills.
      stall_req <= (count_nxt >= STALL_LVL);
      if (wb_req && pend[bus.wb_addr]) err_waw <= 1'b1;
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid = sel_we;
  assign fwd_addr  = sel_addr;
  assign fwd_data  = sel_data;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        wv;
    logic [5:0]  op;
    logic [4:0]  a;
    logic [31:0] d;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pend;
  logic        stall_req, rf_we, err_waw;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        pf_valid = 1'b0;
  logic        pf_ok = 1'b0;
  logic [4:0]  pf_addr;
  logic [31:0] pf_data;
`endif

  int checks = 0;
  int errors = 0;

  rf_write_arbiter_if bus();

  rf_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .pend      (pend),
    .stall_req (stall_req),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .err_waw   (err_waw)
`ifdef WB_FWD_EN
    ,
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit op_writes(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h01) || (op == 6'h02) || (op == 6'h04) ||
           (op == 6'h05) || (op == 6'h06) || (op == 6'h13);
  endfunction

  // ---------------- reference model + scoreboard ----------------
  ent_t        mq[$];
  ent_t        exp_q[$];
  logic [31:0] m_pend = '0;
  bit          m_err = 0, m_stall = 0, m_we = 0, m_lu_acc = 0;
  bit          mon_en = 0, proto_chk = 1;
  bit          md_wbreq, md_acc;
  ent_t        md_e;

  always @(posedge clk) begin
    if (proto_chk && mon_en && !rst && stall_req) check("wb_valid during stall", bus.wb_valid, 0);
    if (rst) begin
      mq.delete();
      m_pend = '0; m_err = 0; m_stall = 0; m_we = 0; m_lu_acc = 0;
    end else begin
      md_wbreq = bus.wb_valid && op_writes(bus.wb_optype) && (bus.wb_addr != 0);
      md_acc   = bus.lu_valid && (mq.size() < DEPTH);
      m_lu_acc = md_acc;
      m_we     = 0;
      if (md_wbreq) begin
        if (m_pend[bus.wb_addr]) m_err = 1;
        md_e.addr = bus.wb_addr; md_e.data = bus.wb_data;
        exp_q.push_back(md_e);
        m_we = 1;
      end else if (mq.size() > 0) begin
        md_e = mq.pop_front();
        m_pend[md_e.addr] = 1'b0;
        exp_q.push_back(md_e);
        m_we = 1;
      end
      if (bus.issue_valid && bus.issue_addr != 0) m_pend[bus.issue_addr] = 1'b1;
      if (md_acc && bus.lu_addr != 0) begin
        md_e.addr = bus.lu_addr; md_e.data = bus.lu_data;
        mq.push_back(md_e);
      end
      m_stall = (mq.size() >= DEPTH - 1);
    end
  end

  ent_t mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      check("rf_we", rf_we, m_we);
      if (m_we) begin
        if (exp_q.size() == 0) begin
          check("scoreboard underflow", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          if (rf_we) begin
            check("rf_addr", rf_addr, mon_e.addr);
            check("rf_data", rf_data, mon_e.data);
          end
        end
      end
      check("pend", pend, m_pend);
      check("err_waw", err_waw, m_err);
      check("stall_req", stall_req, m_stall);
      check("lu_ready", bus.lu_ready, !rst && (mq.size() < DEPTH));
`ifdef WB_FWD_EN
      if (pf_ok && !rst) begin
        check("fwd_valid vs rf_we", rf_we, pf_valid);
        if (pf_valid) begin
          check("fwd_addr vs rf_addr", rf_addr, pf_addr);
          check("fwd_data vs rf_data", rf_data, pf_data);
        end
      end
      pf_ok = !rst; pf_valid = fwd_valid; pf_addr = fwd_addr; pf_data = fwd_data;
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid = 0; bus.wb_optype = 6'h00; bus.wb_addr = 0; bus.wb_data = 0;
    bus.lu_valid = 0; bus.lu_addr = 0; bus.lu_data = 0;
    bus.issue_valid = 0; bus.issue_addr = 0;
  endtask

  task automatic wb(input logic [5:0] op, input logic [4:0] a, input logic [31:0] d);
    bus.wb_valid = 1; bus.wb_optype = op; bus.wb_addr = a; bus.wb_data = d;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1, 6'h00,  5, 32'h1234,     1,  5, 32'h1234};
    vecs[1] = '{1, 6'h03,  6, 32'h5555,     0,  5, 32'h1234};
    vecs[2] = '{1, 6'h00,  0, 32'h7777,     0,  5, 32'h1234};
    vecs[3] = '{0, 6'h01,  8, 32'h8888,     0,  5, 32'h1234};
    vecs[4] = '{1, 6'h13, 31, 32'hDEADBEEF, 1, 31, 32'hDEADBEEF};
    vecs[5] = '{1, 6'h06,  1, 32'h1,        1,  1, 32'h1};
    vecs[6] = '{1, 6'h07,  2, 32'h2,        0,  1, 32'h1};
    vecs[7] = '{1, 6'h04,  2, 32'h22,       1,  2, 32'h22};
    vecs[8] = '{1, 6'h05,  3, 32'h33,       1,  3, 32'h33};
    vecs[9] = '{1, 6'h02,  4, 32'h44,       1,  4, 32'h44};

    idle_inputs();
    rst = 1;
    repeat (3) step();
    check("reset rf_we", rf_we, 0);
    check("reset rf_addr", rf_addr, 0);
    check("reset rf_data", rf_data, 0);
    check("reset pend", pend, 0);
    check("reset stall_req", stall_req, 0);
    check("reset err_waw", err_waw, 0);
    check("lu_ready in reset", bus.lu_ready, 0);
    rst = 0;
    mon_en = 1;
    #1;
    check("lu_ready after release", bus.lu_ready, 1);
    step();

    // single-cycle WB vectors, back to back
    for (int i = 0; i < 10; i++) begin
      bus.wb_valid = vecs[i].wv; bus.wb_optype = vecs[i].op;
      bus.wb_addr = vecs[i].a; bus.wb_data = vecs[i].d;
      step();
      check($sformatf("vec%0d rf_we", i), rf_we, vecs[i].ewe);
      check($sformatf("vec%0d rf_addr", i), rf_addr, vecs[i].ea);
      check($sformatf("vec%0d rf_data", i), rf_data, vecs[i].ed);
    end
    idle_inputs();
    step();

    // issue -> pend, LU commit two cycles after transfer clears it
    bus.issue_valid = 1; bus.issue_addr = 9;
    step();
    bus.issue_valid = 0;
    check("pend9 set", pend[9], 1);
    bus.lu_valid = 1; bus.lu_addr = 9; bus.lu_data = 32'hAAAA;
    step();
    bus.lu_valid = 0;
    check("lu N+1 rf_we", rf_we, 0);
    check("lu N+1 pend9", pend[9], 1);
    step();
    check("lu N+2 rf_we", rf_we, 1);
    check("lu N+2 rf_addr", rf_addr, 9);
    check("lu N+2 rf_data", rf_data, 32'hAAAA);
    check("lu N+2 pend9", pend[9], 0);

    // WAW: WB to a pending register
    bus.issue_valid = 1; bus.issue_addr = 9;
    step();
    bus.issue_valid = 0;
    wb(6'h00, 9, 32'h99);
    step();
    idle_inputs();
    check("waw err", err_waw, 1);
    check("waw write proceeds", rf_addr, 9);
    repeat (3) step();
    check("waw sticky", err_waw, 1);

    // same-cycle set and clear on addr 7
    bus.issue_valid = 1; bus.issue_addr = 7;
    step();
    bus.issue_valid = 0;
    bus.lu_valid = 1; bus.lu_addr = 7; bus.lu_data = 32'h77;
    step();
    bus.lu_valid = 0;
    bus.issue_valid = 1; bus.issue_addr = 7;
    step();
    idle_inputs();
    check("set-wins rf_addr", rf_addr, 7);
    check("set-wins pend7", pend[7], 1);
    step();

    // LU result to r0 is accepted and dropped
    bus.lu_valid = 1; bus.lu_addr = 0; bus.lu_data = 32'hBAD;
    step();
    bus.lu_valid = 0;
    step();
    check("r0 lu no write", rf_we, 0);

    // random traffic honouring the stall protocol
    for (int c = 0; c < 80; c++) begin
      bus.wb_valid = !stall_req && ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 6))
        0: bus.wb_optype = 6'h00; 1: bus.wb_optype = 6'h01; 2: bus.wb_optype = 6'h02;
        3: bus.wb_optype = 6'h03; 4: bus.wb_optype = 6'h13; 5: bus.wb_optype = 6'h05;
        default: bus.wb_optype = 6'h3F;
      endcase
      bus.wb_addr = 5'($urandom_range(0, 31));
      bus.wb_data = $urandom;
      bus.issue_valid = ($urandom_range(0, 3) == 0);
      bus.issue_addr = 5'($urandom_range(0, 31));
      if (!bus.lu_valid && $urandom_range(0, 1) == 1) begin
        bus.lu_valid = 1;
        bus.lu_addr = 5'($urandom_range(0, 31));
        bus.lu_data = $urandom;
      end
      step();
      if (m_lu_acc) bus.lu_valid = 0;
    end
    bus.wb_valid = 0; bus.issue_valid = 0;
    for (int c = 0; c < 10 && bus.lu_valid; c++) begin
      step();
      if (m_lu_acc) bus.lu_valid = 0;
    end
    check("lu drain bound", bus.lu_valid, 0);
    idle_inputs();
    repeat (3) step();

    // WB every cycle while LU offers two results: buffer fills
    proto_chk = 0;
    wb(6'h00, 3, 32'h300);
    bus.lu_valid = 1; bus.lu_addr = 10; bus.lu_data = 32'h1010;
    step();
    wb(6'h00, 3, 32'h301);
    bus.lu_addr = 11; bus.lu_data = 32'h1111;
    step();
    bus.lu_valid = 0;
    check("full lu_ready", bus.lu_ready, 0);
    check("full stall_req", stall_req, 1);
    wb(6'h00, 3, 32'h302);
    step();
    check("full wb wins", rf_data, 32'h302);
    bus.wb_valid = 0;
    step();
    check("drain1 addr", rf_addr, 10);
    check("drain1 data", rf_data, 32'h1010);
    step();
    check("drain2 addr", rf_addr, 11);
    check("drain2 data", rf_data, 32'h1111);
    step();
    check("drained no write", rf_we, 0);
    proto_chk = 1;

    // reset with two buffered entries and a pending bit
    proto_chk = 0;
    wb(6'h00, 4, 32'h400);
    bus.lu_valid = 1; bus.lu_addr = 12; bus.lu_data = 32'h1212;
    bus.issue_valid = 1; bus.issue_addr = 20;
    step();
    bus.issue_valid = 0;
    wb(6'h00, 4, 32'h401);
    bus.lu_addr = 13; bus.lu_data = 32'h1313;
    step();
    idle_inputs();
    check("pre-rst pend20", pend[20], 1);
    rst = 1;
    step();
    check("rst rf_we", rf_we, 0);
    check("rst pend", pend, 0);
    check("rst err_waw", err_waw, 0);
    check("rst lu_ready", bus.lu_ready, 0);
    rst = 0;
    proto_chk = 1;
    #1;
    check("post-rst lu_ready", bus.lu_ready, 1);
    for (int c = 0; c < 4; c++) begin
      step();
      check("no stale write", rf_we, 0);
    end

    check("scoreboard empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end
endmodule
